// File: rtl/framebuffer_writer_if.sv
// Purpose : pixel-input and framebuffer-write bus between renderer/memory and framebuffer_writer.
// Latency : none (wires only).
// Backpressure: ready gates plot on the pixel side; mem_stall holds the write port on the memory side.
// Ports   : plot/x/y/color/ready (pixel handshake), mem_addr/mem_data/mem_we/mem_stall (write port).
//           master = the environment (renderer + memory), slave = framebuffer_writer.
interface framebuffer_writer_if;
  logic        plot;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [8:0]  color;
  logic        ready;
  logic [15:0] mem_addr;
  logic [8:0]  mem_data;
  logic        mem_we;
  logic        mem_stall;

  modport master (
    output plot, x, y, color, mem_stall,
    input  ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  plot, x, y, color, mem_stall,
    output ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Purpose : queues renderer pixels and writes them into the back half of a double-buffered
//           framebuffer; swaps front/back buffers on frame_done once drained and in vblank.
// Latency : pixel accepted at edge N (empty queue, no stall) is on mem_we/mem_addr/mem_data after N+1.
// Backpressure: ready drops when the queue is full or outside ACTIVE; mem_stall freezes the write port.
// Ports   : clk, reset (async, active-high); bus (slave modport: pixel handshake + write port);
//           frame_done/vblank control inputs; front_sel, swapped pulse, dropped saturating count.
module framebuffer_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4    // power of two, at least 2
) (
  input  logic                clk,
  input  logic                reset,
  framebuffer_writer_if.slave bus,
  input  logic                frame_done,
  input  logic                vblank,
  output logic                front_sel,
  output logic                swapped,
  output logic [7:0]          dropped
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] WIDTH_U = WIDTH;
  localparam logic [31:0] HEIGHT_U = HEIGHT;
  localparam logic [15:0] W16     = 16'(WIDTH);
  localparam logic [15:0] FRAME16 = 16'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {ACTIVE, DRAIN, WAIT_VBLANK, SWAP} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  data;
  } px_t;

  state_t          state_q, state_d;
  px_t             fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fd_q;
  logic            front_sel_q;
  logic            swapped_q;
  logic [7:0]      dropped_q;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [8:0]      mem_data_q, mem_data_d;

  logic            ready;
  logic            in_range;
  logic            accept, push, drop, pop;
  logic            fd_rise;
  logic            write_phase;
  logic [CW-1:0]   avail;
  logic [AW-1:0]   head_idx;
  logic [15:0]     pix_addr;
  px_t             head;

  assign ready    = (cnt_q != DEPTH_C) && (state_q == ACTIVE);
  assign in_range = ({22'd0, bus.x} < WIDTH_U) && ({22'd0, bus.y} < HEIGHT_U);
  assign accept   = bus.plot && ready;
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;

  // The head entry stays queued while it sits on the write port; it leaves on a non-stalled edge.
  assign pop      = mem_we_q && !bus.mem_stall;
  assign fd_rise  = frame_done && !fd_q;

  // Back buffer is the half not being scanned out. front_sel cannot change while pixels are
  // queued (swap only happens after a full drain), so the address is resolved at push time.
  assign pix_addr = (front_sel_q ? 16'd0 : FRAME16) + 16'(bus.y) * W16 + 16'(bus.x);

  // Entries remaining after this edge's pop; a pixel pushed on this same edge is not yet
  // eligible for the write port, which gives the one-cycle queue latency.
  assign avail       = cnt_q - {{(CW-1){1'b0}}, pop};
  assign head_idx    = rd_ptr_q + AW'(pop);
  assign head        = fifo_q[head_idx];
  assign write_phase = (state_q == ACTIVE) || (state_q == DRAIN);

  always_comb begin
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (!(mem_we_q && bus.mem_stall)) begin
      if ((avail != '0) && write_phase) begin
        mem_we_d   = 1'b1;
        mem_addr_d = head.addr;
        mem_data_d = head.data;
      end else begin
        mem_we_d   = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:      if (fd_rise) state_d = DRAIN;
      DRAIN:       if ((cnt_q == '0) && !mem_we_q) state_d = WAIT_VBLANK;
      WAIT_VBLANK: if (vblank) state_d = SWAP;
      SWAP:        state_d = ACTIVE;
      default:     state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACTIVE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      fd_q        <= 1'b0;
      front_sel_q <= 1'b0;
      swapped_q   <= 1'b0;
      dropped_q   <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_data_q  <= 9'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fd_q        <= frame_done;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;
      // swapped is raised alongside the new front_sel value for one cycle
      front_sel_q <= front_sel_q ^ (state_q == SWAP);
      swapped_q   <= (state_q == SWAP);
    end
  end

  // Queue storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: pix_addr, data: bus.color};
  end

  assign bus.ready    = ready;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign front_sel    = front_sel_q;
  assign swapped      = swapped_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       frame_done;
  logic       vblank;
  logic       front_sel;
  logic       swapped;
  logic [7:0] dropped;

  framebuffer_writer_if bus();

  framebuffer_writer #(.WIDTH(160), .HEIGHT(120), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .vblank     (vblank),
    .front_sel  (front_sel),
    .swapped    (swapped),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  data;
  } exp_t;

  typedef struct {
    int          px;
    int          py;
    int          pc;
    bit          inr;
    logic [15:0] addr;
    int          drop;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_writes = 0;
  int   swap_cnt = 0;
  bit   exp_front = 1'b0;

  function automatic void chk(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  function automatic logic [15:0] exp_addr(input int px, input int py);
    return 16'((exp_front ? 0 : 19200) + py * 160 + px);
  endfunction

  // Scoreboard: every completed write (mem_we and no stall) must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.mem_we && !bus.mem_stall) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", int'(bus.mem_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk(bus.mem_addr == e.addr, "wr_addr", int'(bus.mem_addr), int'(e.addr));
          chk(bus.mem_data == e.data, "wr_data", int'(bus.mem_data), int'(e.data));
        end
      end
      if (swapped) swap_cnt++;
    end
  end

  // Presents a pixel for one edge; acc reports whether ready was high, i.e. it was taken.
  task automatic drive_px(input int px, input int py, input int pc,
                          input logic [15:0] ea, input bit inr, output bit acc);
    @(negedge clk);
    bus.plot  = 1'b1;
    bus.x     = 10'(px);
    bus.y     = 10'(py);
    bus.color = 9'(pc);
    acc = bus.ready;
    if (acc && inr) exp_q.push_back('{addr: ea, data: 9'(pc)});
    @(posedge clk);
    #1 bus.plot = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vecs[8];
    bit   acc;
    int   idx;
    int   acc6;
    int   w0;

    vecs[0] = '{0,    0,    9'h001, 1'b1, 16'd19200, 0};
    vecs[1] = '{159,  119,  9'h1FF, 1'b1, 16'd38399, 0};
    vecs[2] = '{160,  0,    9'h000, 1'b0, 16'd0,     1};
    vecs[3] = '{0,    120,  9'h000, 1'b0, 16'd0,     2};
    vecs[4] = '{5,    7,    9'h0AA, 1'b1, 16'd20325, 2};
    vecs[5] = '{1023, 1023, 9'h000, 1'b0, 16'd0,     3};
    vecs[6] = '{159,  0,    9'h155, 1'b1, 16'd19359, 3};
    vecs[7] = '{0,    119,  9'h03F, 1'b1, 16'd38240, 3};

    reset = 1'b1;
    bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.color = '0; bus.mem_stall = 1'b0;
    frame_done = 1'b0; vblank = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk(bus.mem_we == 1'b0, "rst_mem_we", int'(bus.mem_we), 0);
    chk(bus.mem_addr == 16'd0, "rst_mem_addr", int'(bus.mem_addr), 0);
    chk(bus.mem_data == 9'd0, "rst_mem_data", int'(bus.mem_data), 0);
    chk(front_sel == 1'b0, "rst_front_sel", int'(front_sel), 0);
    chk(swapped == 1'b0, "rst_swapped", int'(swapped), 0);
    chk(dropped == 8'd0, "rst_dropped", int'(dropped), 0);
    reset = 1'b0;
    @(negedge clk);
    chk(bus.ready == 1'b1, "rst_ready", int'(bus.ready), 1);

    // single pixel latency: accepted at edge N, visible after N+1 for exactly one cycle
    drive_px(3, 2, 9'h1C0, 16'd19523, 1'b1, acc);
    chk(acc, "lat_accept", int'(acc), 1);
    @(negedge clk);
    chk(bus.mem_we == 1'b0, "lat_early", int'(bus.mem_we), 0);
    @(negedge clk);
    chk(bus.mem_we == 1'b1, "lat_we", int'(bus.mem_we), 1);
    chk(bus.mem_addr == 16'd19523, "lat_addr", int'(bus.mem_addr), 19523);
    chk(bus.mem_data == 9'h1C0, "lat_data", int'(bus.mem_data), 'h1C0);
    @(negedge clk);
    chk(bus.mem_we == 1'b0, "lat_pulse", int'(bus.mem_we), 0);

    // table of single pixels, in and out of range
    for (int i = 0; i < 8; i++) begin
      drive_px(vecs[i].px, vecs[i].py, vecs[i].pc, vecs[i].addr, vecs[i].inr, acc);
      chk(acc, "vec_accept", int'(acc), 1);
      repeat (4) @(negedge clk);
      chk(dropped == 8'(vecs[i].drop), "vec_dropped", int'(dropped), vecs[i].drop);
      chk(exp_q.size() == 0, "vec_written", exp_q.size(), 0);
    end

    // stalled memory: queue fills after 4, holds the write port, then drains in order
    @(posedge clk);
    #1 bus.mem_stall = 1'b1;
    idx = 0;
    acc6 = 0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      drive_px(10 + idx, 1, idx + 1, exp_addr(10 + idx, 1), 1'b1, acc);
      if (acc) idx++;
      if (acc && cyc < 6) acc6++;
      if (cyc == 4 || cyc == 5) chk(!acc, "stall_ready_low", int'(acc), 0);
      if (cyc == 5) begin
        chk(bus.mem_we == 1'b1, "stall_hold_we", int'(bus.mem_we), 1);
        chk(bus.mem_addr == exp_addr(10, 1), "stall_hold_addr", int'(bus.mem_addr), int'(exp_addr(10, 1)));
        bus.mem_stall = 1'b0;
      end
    end
    chk(acc6 == 4, "stall_accepts", acc6, 4);
    chk(idx == 6, "stall_all_accepted", idx, 6);
    wait_idle("stall_drain");

    // saturation of the drop counter
    for (int i = 0; i < 300; i++) drive_px(200, 5, 0, 16'd0, 1'b0, acc);
    @(negedge clk);
    chk(dropped == 8'd255, "drop_sat", int'(dropped), 255);

    // frame swap: drain 3 queued pixels, wait for vblank, swap once
    @(posedge clk);
    #1 bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) drive_px(20 + i, 3, 9'h010 + i, exp_addr(20 + i, 3), 1'b1, acc);
    @(negedge clk);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    chk(bus.ready == 1'b0, "drain_ready", int'(bus.ready), 0);
    bus.mem_stall = 1'b0;
    wait_idle("drain_writes");
    repeat (5) @(negedge clk);
    chk(front_sel == 1'b0, "wait_front", int'(front_sel), 0);
    chk(swap_cnt == 0, "wait_no_swap", swap_cnt, 0);
    chk(bus.ready == 1'b0, "wait_ready", int'(bus.ready), 0);
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    chk(swap_cnt == 1, "swap_once", swap_cnt, 1);
    chk(front_sel == 1'b1, "swap_front", int'(front_sel), 1);
    chk(bus.ready == 1'b1, "swap_ready", int'(bus.ready), 1);
    chk(dropped == 8'd255, "drop_kept", int'(dropped), 255);
    exp_front = 1'b1;
    drive_px(0, 0, 9'h007, exp_addr(0, 0), 1'b1, acc);
    wait_idle("front1_write");

    // frame_done still high after the swap: no further swap
    repeat (20) @(negedge clk);
    chk(swap_cnt == 1, "fd_held_no_swap", swap_cnt, 1);

    // fall then rise starts a new drain; reset in the middle discards everything
    vblank = 1'b0;
    frame_done = 1'b0;
    @(posedge clk);
    #1 bus.mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) drive_px(30 + i, 4, 9'h020 + i, exp_addr(30 + i, 4), 1'b1, acc);
    @(negedge clk);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    chk(bus.ready == 1'b0, "drain2_ready", int'(bus.ready), 0);
    chk(bus.mem_we == 1'b1, "drain2_we_held", int'(bus.mem_we), 1);
    reset = 1'b1;
    #1;
    chk(bus.mem_we == 1'b0, "rst_drain_we", int'(bus.mem_we), 0);
    chk(front_sel == 1'b0, "rst_drain_front", int'(front_sel), 0);
    chk(dropped == 8'd0, "rst_drain_dropped", int'(dropped), 0);
    exp_q.delete();
    exp_front = 1'b0;
    frame_done = 1'b0;
    bus.mem_stall = 1'b0;
    vblank = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    w0 = n_writes;
    repeat (20) @(negedge clk);
    chk(swap_cnt == 1, "no_swap_after_rst", swap_cnt, 1);
    chk(front_sel == 1'b0, "front_after_rst", int'(front_sel), 0);
    chk(n_writes == w0, "no_write_after_rst", n_writes, w0);

    // a fresh rising edge after reset yields exactly one more swap
    frame_done = 1'b1;
    repeat (10) @(negedge clk);
    chk(swap_cnt == 2, "second_swap", swap_cnt, 2);
    chk(front_sel == 1'b1, "second_swap_front", int'(front_sel), 1);
    chk(exp_q.size() == 0, "sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
